// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command controller behind an SPI slave.
// Decodes the received byte stream into register-bus reads/writes and
// sequences the slave's tx byte. The slave only loads tx at frame start, so
// read data and STATUS bytes surface in the first byte of the following frame.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no frame being parsed; waiting for a frame start
// CMD     | frame open, waiting for the command byte
// WDATA   | write command taken; each byte is written, address auto-increments
// RD_REQ  | read strobe on the bus, arming the timeout counter
// RD_WAIT | waiting for reg_rvalid or timeout; address held
// DRAIN   | read answered, remaining bytes of the frame are discarded
module spi_reg_ctrl #(
    parameter int ADDR_W     = 7,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_active,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic [1:0]        err_flags
);

    localparam int CW = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RD_REQ, RD_WAIT, DRAIN} state_t;

    state_t            state, state_d;
    logic              fa_r1, fa_r2;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d, tx_data_d;
    logic              we_d, re_d, tx_valid_d;
    logic              rd_late, rd_late_d, rd_to, rd_to_d, wr_seen, wr_seen_d;
    logic              end_pend, end_pend_d, new_frm, new_frm_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              frm_start, frm_end, byte_ok, rd_done;
    logic              status_ld, set_late, set_to, set_wr;
    logic [7:0]        status;

    assign frm_start = fa_r1 & ~fa_r2;
    assign frm_end   = ~fa_r1 & fa_r2;
    assign byte_ok   = rx_valid & fa_r2;
    assign status    = {4'hA, 1'b0, rd_late, rd_to, wr_seen};
    assign err_flags = {rd_late, rd_to};

    // State and output registers. The frame_active history resets to "in a
    // frame" so a reset inside a frame cannot fake a new frame start; the
    // remainder of that frame is then dropped in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fa_r1     <= 1'b1;
            fa_r2     <= 1'b1;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            rd_late   <= 1'b0;
            rd_to     <= 1'b0;
            wr_seen   <= 1'b0;
            end_pend  <= 1'b0;
            new_frm   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            fa_r1     <= frame_active;
            fa_r2     <= fa_r1;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            reg_we    <= we_d;
            reg_re    <= re_d;
            tx_data   <= tx_data_d;
            tx_valid  <= tx_valid_d;
            rd_late   <= rd_late_d;
            rd_to     <= rd_to_d;
            wr_seen   <= wr_seen_d;
            end_pend  <= end_pend_d;
            new_frm   <= new_frm_d;
            cnt       <= cnt_d;
        end
    end

    // Next-state, bus strobes, tx sequencing and sticky flag handling.
    always_comb begin
        state_d    = state;
        addr_d     = reg_addr;
        wdata_d    = reg_wdata;
        we_d       = 1'b0;
        re_d       = 1'b0;
        tx_data_d  = tx_data;
        tx_valid_d = 1'b0;
        rd_late_d  = rd_late;
        rd_to_d    = rd_to;
        wr_seen_d  = wr_seen;
        end_pend_d = end_pend;
        new_frm_d  = new_frm;
        cnt_d      = cnt;
        status_ld  = 1'b0;
        set_late   = 1'b0;
        set_to     = 1'b0;
        set_wr     = 1'b0;
        rd_done    = 1'b0;

        // address advances in the cycle the write strobe is on the bus
        if (reg_we) addr_d = reg_addr + 1'b1;

        case (state)
            IDLE: begin
                if (frm_start) begin
                    state_d    = CMD;
                    end_pend_d = 1'b0;
                end
            end
            CMD: begin
                if (byte_ok) begin
                    addr_d = rx_data[ADDR_W-1:0];
                    if (rx_data[7]) begin
                        re_d      = 1'b1;
                        new_frm_d = 1'b0;
                        state_d   = RD_REQ;
                    end else begin
                        end_pend_d = frm_end;
                        state_d    = WDATA;
                    end
                end else if (frm_end) begin
                    status_ld = 1'b1;
                    state_d   = IDLE;
                end
            end
            WDATA: begin
                if (byte_ok) begin
                    wdata_d = rx_data;
                    we_d    = 1'b1;
                    set_wr  = 1'b1;
                    if (frm_end) end_pend_d = 1'b1;
                end else if (frm_end || end_pend) begin
                    status_ld  = 1'b1;
                    end_pend_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            RD_REQ: begin
                cnt_d   = CW'(RD_TIMEOUT);
                state_d = RD_WAIT;
                if (frm_start) begin
                    set_late  = 1'b1;
                    new_frm_d = 1'b1;
                end
            end
            RD_WAIT: begin
                if (frm_start) begin
                    set_late  = 1'b1;
                    new_frm_d = 1'b1;
                end
                if (reg_rvalid) begin
                    tx_data_d  = reg_rdata;
                    tx_valid_d = 1'b1;
                    rd_done    = 1'b1;
                end else if (cnt <= CW'(1)) begin
                    tx_data_d  = 8'hEE;
                    tx_valid_d = 1'b1;
                    set_to     = 1'b1;
                    rd_done    = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
                // a frame that opened during the read is parsed from its next byte
                if (rd_done) begin
                    new_frm_d  = 1'b0;
                    end_pend_d = 1'b0;
                    if (new_frm || frm_start) state_d = fa_r1 ? CMD : IDLE;
                    else                      state_d = fa_r1 ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (frm_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (status_ld) begin
            tx_data_d  = status;
            tx_valid_d = 1'b1;
            rd_late_d  = 1'b0;
            rd_to_d    = 1'b0;
            wr_seen_d  = 1'b0;
        end
        if (set_late) rd_late_d = 1'b1;
        if (set_to)   rd_to_d   = 1'b1;
        if (set_wr)   wr_seen_d = 1'b1;
    end

endmodule
